// File: rtl/axis_pulse_rx_buffer_if.sv
// AXI-stream bundle (data/user/dest/valid/ready) used on the buffered output side.
// Master drives payload and valid; slave returns ready.
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int DEST_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;
  logic [DEST_WIDTH-1:0] dest;
  logic                  valid;
  logic                  ready;

  modport master (output data, output user, output dest, output valid, input ready);
  modport slave  (input data, input user, input dest, input valid, output ready);
endinterface

// File: rtl/axis_pulse_rx_buffer.sv
// Pulse-strobed word stream -> FWFT FIFO -> AXI stream; AXIS_PULSE_RX_DROP_COUNT_EN adds a drop counter.
// Latency: strobe at edge N shows on out.valid/out.data after edge N; one word per cycle each way.
// Backpressure: input cannot be stalled; a word arriving when full without a pop is dropped and flagged.
module axis_pulse_rx_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int DEST_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [USER_WIDTH-1:0]   in_user,
  input  logic [DEST_WIDTH-1:0]   in_dest,
  axi_stream.master               out,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    clear_overflow,
  output logic [15:0]             drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [USER_WIDTH-1:0] user;
    logic [DEST_WIDTH-1:0] dest;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_word;
  entry_t          head_q;
  entry_t          head_d;
  logic            head_vld;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_next;
  logic [LW-1:0]   level_d;
  logic            pop;
  logic            push;
  logic            drop;

  assign in_word = '{data: in_data, user: in_user, dest: in_dest};
  assign rd_next = rd_ptr + AW'(1);

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop  = head_vld & out.ready;
  assign push = in_valid & ((level != FULL) | pop);
  assign drop = in_valid & (level == FULL) & ~pop;

  always_comb begin
    level_d = level;
    unique case ({push, pop})
      2'b10:   level_d = level + LW'(1);
      2'b01:   level_d = level - LW'(1);
      default: level_d = level;
    endcase
  end

  // Output register always mirrors the head; the next head is either the
  // stored successor or, when that slot is being written now, the input word.
  always_comb begin
    head_d = head_q;
    if (level == '0) begin
      if (push) head_d = in_word;
    end else if (pop) begin
      if (level == LW'(1)) begin
        if (push) head_d = in_word;
      end else begin
        head_d = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      head_q   <= '0;
      head_vld <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next;
      level    <= level_d;
      head_q   <= head_d;
      head_vld <= (level_d != '0);
    end
  end

  assign out.data  = head_q.data;
  assign out.user  = head_q.user;
  assign out.dest  = head_q.dest;
  assign out.valid = head_vld;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef AXIS_PULSE_RX_DROP_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (clear_overflow) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_pulse_rx_buffer.sv
// Bench for axis_pulse_rx_buffer: queue model of the FIFO checked every cycle, plus literal expectations.
module tb_axis_pulse_rx_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] in_user = '0;
  logic [31:0] in_dest = '0;
  logic        clear_overflow = 1'b0;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  axi_stream #(.DATA_WIDTH(32), .USER_WIDTH(32), .DEST_WIDTH(32)) axis ();

  axis_pulse_rx_buffer #(
    .DEPTH(DEPTH), .DATA_WIDTH(32), .USER_WIDTH(32), .DEST_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_user(in_user),
    .in_dest(in_dest),
    .out(axis),
    .level(level),
    .overflow(overflow),
    .clear_overflow(clear_overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] u;
    logic [31:0] t;
  } word_t;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  word_t mq[$];
  logic  m_ovf = 1'b0;
  int    m_dc = 0;
  word_t got[$];
  int    got_cyc[$];
  bit    stream_phase = 1'b0;
  bit    prev_stall = 1'b0;
  word_t prev_word;
  bit    mpop, mpush, mdrop;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge and stay put until the next edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [31:0] u,
                      input logic [31:0] t, input logic rdy, input logic clr);
    @(posedge clock);
    #1;
    in_valid = v; in_data = d; in_user = u; in_dest = t;
    axis.ready = rdy; clear_overflow = clr;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  function automatic logic [15:0] exp_dc(input int n);
`ifdef AXIS_PULSE_RX_DROP_COUNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  // Model: a queue of stored words, a sticky flag and a saturating count.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      cyc++;
      mpop  = (mq.size() != 0) && axis.ready;
      mpush = in_valid && ((mq.size() < DEPTH) || mpop);
      mdrop = in_valid && !mpush;
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back('{d: in_data, u: in_user, t: in_dest});
      if (clear_overflow) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end else if (mdrop) begin
        m_ovf = 1'b1;
        if (m_dc < 65535) m_dc++;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("valid", axis.valid, mq.size() != 0);
      chk("level", level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, exp_dc(m_dc));
      if (mq.size() != 0) begin
        chk("data", axis.data, mq[0].d);
        chk("user", axis.user, mq[0].u);
        chk("dest", axis.dest, mq[0].t);
      end
      if (prev_stall) chk("stall_stable", {axis.data, axis.user, axis.dest}, prev_word);
      if (stream_phase) begin
        chk("stream_level_le1", level <= 3'd1, 1'b1);
        chk("stream_overflow", overflow, 1'b0);
      end
      if (axis.valid && axis.ready) begin
        got.push_back('{d: axis.data, u: axis.user, t: axis.dest});
        got_cyc.push_back(cyc);
      end
      prev_stall = axis.valid && !axis.ready;
      prev_word  = '{d: axis.data, u: axis.user, t: axis.dest};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    axis.ready = 1'b0;
    // Reset held from time zero.
    idle(1'b0, 3);
    @(negedge clock);
    chk("rst0_valid", axis.valid, 1'b0);
    chk("rst0_level", level, 3'd0);
    chk("rst0_data", axis.data, 32'd0);
    @(posedge clock); #1; reset = 1'b1;

    // Async reset mid-stream with three words stored.
    step(1'b1, 32'd11, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'd12, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'd13, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(1'b0, 1);
    @(negedge clock);
    chk("pre_rst_level", level, 3'd3);
    reset = 1'b0;
    #1;
    chk("rst_valid", axis.valid, 1'b0);
    chk("rst_data", axis.data, 32'd0);
    chk("rst_user", axis.user, 32'd0);
    chk("rst_dest", axis.dest, 32'd0);
    chk("rst_level", level, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_count", drop_count, 16'd0);
    in_valid = 1'b0;
    idle(1'b0, 2);
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0001;
    idle(1'b0, 1);
    @(negedge clock);
    chk("post_rst_valid", axis.valid, 1'b1);
    chk("post_rst_data", axis.data, 32'hA5A5_0001);
    idle(1'b1, 3);

    // Back-to-back streaming with ready held high.
    got.delete(); got_cyc.delete();
    stream_phase = 1'b1;
    for (int i = 0; i < 100; i++) step(1'b1, 32'(i), 32'(i), 32'(i), 1'b1, 1'b0);
    idle(1'b1, 3);
    @(negedge clock);
    stream_phase = 1'b0;
    chk("stream_count", got.size(), 100);
    for (int i = 0; i < got.size(); i++) begin
      chk("stream_order", got[i].d, 32'(i));
      chk("stream_no_gap", got_cyc[i], got_cyc[0] + i);
    end

    // Fill and overflow: six strobes into four slots.
    for (int i = 1; i <= 6; i++) step(1'b1, 32'(i), 32'(i), 32'(i), 1'b0, 1'b0);
    idle(1'b0, 1);
    @(negedge clock);
    chk("fill_level", level, 3'd4);
    chk("fill_overflow", overflow, 1'b1);
    chk("fill_drop_count", drop_count, exp_dc(2));
    chk("fill_head", axis.data, 32'd1);
    got.delete();
    idle(1'b1, 6);
    idle(1'b0, 1);
    @(negedge clock);
    chk("drain_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("drain_order", got[i].d, 32'(i + 1));
    chk("drain_sticky", overflow, 1'b1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(1'b0, 1);

    // Full with a simultaneous push and pop.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 32'(i), 32'(i), 1'b0, 1'b0);
    got.delete();
    step(1'b1, 32'd5, 32'd5, 32'd5, 1'b1, 1'b0);
    idle(1'b0, 1);
    @(negedge clock);
    chk("pp_level", level, 3'd4);
    chk("pp_overflow", overflow, 1'b0);
    chk("pp_head", axis.data, 32'd2);
    idle(1'b1, 6);
    idle(1'b0, 1);
    @(negedge clock);
    chk("pp_count", got.size(), 5);
    for (int i = 0; i < got.size(); i++) chk("pp_order", got[i].d, 32'(i + 1));

    // Random backpressure at about 30% ready.
    got.delete();
    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 1) == 1, 32'(i), 32'(3 * i), 32'(i) ^ 32'hFF,
           $urandom_range(0, 9) < 3, 1'b0);
    idle(1'b1, 6);
    @(negedge clock);
    chk("bp_some", got.size() > 0, 1'b1);
    for (int i = 0; i < got.size(); i++) begin
      chk("bp_user", got[i].u, 32'(3 * got[i].d));
      chk("bp_dest", got[i].t, got[i].d ^ 32'hFF);
      if (i > 0) chk("bp_order", got[i].d > got[i-1].d, 1'b1);
    end
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(1'b0, 1);

    // Clear wins over a drop in the same cycle.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 32'(i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'd9, 32'd9, 32'd9, 1'b0, 1'b1);
    idle(1'b0, 1);
    @(negedge clock);
    chk("clr_overflow", overflow, 1'b0);
    chk("clr_drop_count", drop_count, 16'd0);
    step(1'b1, 32'd10, 32'd10, 32'd10, 1'b0, 1'b0);
    idle(1'b0, 1);
    @(negedge clock);
    chk("redrop_overflow", overflow, 1'b1);
    chk("redrop_drop_count", drop_count, exp_dc(1));
    chk("redrop_level", level, 3'd4);
    idle(1'b1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
